regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load writeback arbiter for the regfile write port with pending-load scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int MAXSTALL = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            pend_set,
  input  logic [AW-1:0]   pend_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata
);
  localparam int NREG = 2**AW;
  localparam int SW = (MAXSTALL > 0) ? $clog2(MAXSTALL + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(MAXSTALL);

  logic [SW-1:0]   stall_cnt, stall_cnt_next;
  logic [NREG-1:0] pend, pend_next;
  logic            rf_from_mem;
  logic            alu_grant, mem_grant;

  // MEM has priority until the ALU has been blocked MAXSTALL cycles in a row
  always_comb begin
    alu_grant = alu_valid && (!mem_valid || stall_cnt == STALL_MAX);
    mem_grant = mem_valid && !alu_grant;
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_comb begin
    stall_cnt_next = '0;
    if (alu_valid && !alu_grant) begin
      if (stall_cnt != STALL_MAX) stall_cnt_next = stall_cnt + SW'(1);
      else                        stall_cnt_next = stall_cnt;
    end
  end

  // set is applied after clear so a newly issued load supersedes the returning one
  always_comb begin
    pend_next = pend;
    if (mem_grant) pend_next[mem_rd] = 1'b0;
    if (pend_set)  pend_next[pend_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we       <= 1'b0;
      rf_rd       <= '0;
      rf_wdata    <= '0;
      rf_from_mem <= 1'b0;
      stall_cnt   <= '0;
      pend        <= '0;
    end else begin
      stall_cnt <= stall_cnt_next;
      pend      <= pend_next;
      if (alu_grant) begin
        rf_we       <= (alu_rd != '0);
        rf_rd       <= alu_rd;
        rf_wdata    <= alu_data;
        rf_from_mem <= 1'b0;
      end else if (mem_grant) begin
        rf_we       <= (mem_rd != '0);
        rf_rd       <= mem_rd;
        rf_wdata    <= mem_data;
        rf_from_mem <= 1'b1;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  // a load in the output stage has left the scoreboard but is not yet in the regfile
  assign rs1_busy = pend[rs1] || (rf_we && rf_from_mem && rf_rd == rs1);
  assign rs2_busy = pend[rs2] || (rf_we && rf_from_mem && rf_rd == rs2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int MAXSTALL = 3;

  logic            clk, rstn;
  logic            alu_valid, mem_valid, pend_set;
  logic [AW-1:0]   alu_rd, mem_rd, pend_rd, rs1, rs2;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, rs1_busy, rs2_busy, rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .MAXSTALL(MAXSTALL)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .pend_set(pend_set), .pend_rd(pend_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned av, ard, ad, mv, mrd, md, ps, prd, r1, r2;
    int unsigned ear, emr, eb1, eb2, ewe, erd, ewd;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: pending loads as a set of registers, output stage as the last accepted write
  bit          m_pend [32];
  int          m_blocked;
  bit          m_we, m_from_mem;
  int unsigned m_rd, m_data;
  bit          last_alu_g, last_mem_g;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_alu_g();
    return alu_valid && (!mem_valid || m_blocked >= MAXSTALL);
  endfunction

  function automatic bit m_mem_g();
    return mem_valid && !m_alu_g();
  endfunction

  function automatic bit m_busy(input int unsigned r);
    return m_pend[r] || (m_we && m_from_mem && m_rd == r);
  endfunction

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_blocked = 0; m_we = 0; m_from_mem = 0; m_rd = 0; m_data = 0;
    last_alu_g = 0; last_mem_g = 0;
  endtask

  task automatic m_update();
    bit ag, mg;
    ag = m_alu_g();
    mg = m_mem_g();
    if (ag) begin
      m_rd = 32'(alu_rd); m_data = alu_data; m_we = (alu_rd != 0); m_from_mem = 0;
    end else if (mg) begin
      m_rd = 32'(mem_rd); m_data = mem_data; m_we = (mem_rd != 0); m_from_mem = 1;
    end else begin
      m_we = 0;
    end
    if (mg) m_pend[mem_rd] = 1'b0;
    if (pend_set && pend_rd != 0) m_pend[pend_rd] = 1'b1;
    if (alu_valid && !ag) m_blocked = (m_blocked + 1 > MAXSTALL) ? MAXSTALL : m_blocked + 1;
    else m_blocked = 0;
    last_alu_g = ag;
    last_mem_g = mg;
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av[0]; alu_rd = v.ard[AW-1:0]; alu_data = v.ad;
    mem_valid = v.mv[0]; mem_rd = v.mrd[AW-1:0]; mem_data = v.md;
    pend_set = v.ps[0]; pend_rd = v.prd[AW-1:0];
    rs1 = v.r1[AW-1:0]; rs2 = v.r2[AW-1:0];
  endtask

  // called just after a posedge with inputs already driven; expectations from table or model
  task automatic step(input bit tbl, input vec_t v, input string tag);
    int unsigned ear, emr, eb1, eb2, ewe, erd, ewd;
    #2;
    ear = m_alu_g(); emr = m_mem_g(); eb1 = m_busy(32'(rs1)); eb2 = m_busy(32'(rs2));
    if (tbl) begin ear = v.ear; emr = v.emr; eb1 = v.eb1; eb2 = v.eb2; end
    check({tag, "_alu_ready"}, 32'(alu_ready), ear);
    check({tag, "_mem_ready"}, 32'(mem_ready), emr);
    check({tag, "_rs1_busy"}, 32'(rs1_busy), eb1);
    check({tag, "_rs2_busy"}, 32'(rs2_busy), eb2);
    @(posedge clk);
    m_update();
    #1;
    ewe = m_we; erd = m_rd; ewd = m_data;
    if (tbl) begin ewe = v.ewe; erd = v.erd; ewd = v.ewd; end
    check({tag, "_rf_we"}, 32'(rf_we), ewe);
    check({tag, "_rf_rd"}, 32'(rf_rd), erd);
    check({tag, "_rf_wdata"}, rf_wdata, ewd);
  endtask

  vec_t tbl [18];
  vec_t rv;

  initial begin
    //           av ard ad            mv mrd md       ps prd r1 r2  ear emr eb1 eb2 ewe erd ewd
    tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,       0, 0,  0, 0,  1,  0,  0,  0,  1,  5,  32'hDEADBEEF};
    tbl[1]  = '{0, 0,  0,            0, 0,  0,       0, 0,  5, 0,  0,  0,  0,  0,  0,  5,  32'hDEADBEEF};
    tbl[2]  = '{1, 3,  32'hA1,       1, 4,  32'hB1,  1, 7,  7, 0,  0,  1,  0,  0,  1,  4,  32'hB1};
    tbl[3]  = '{1, 3,  32'hA1,       1, 6,  32'hB2,  0, 0,  7, 4,  0,  1,  1,  1,  1,  6,  32'hB2};
    tbl[4]  = '{1, 3,  32'hA1,       1, 8,  32'hB3,  0, 0,  7, 6,  0,  1,  1,  1,  1,  8,  32'hB3};
    tbl[5]  = '{1, 3,  32'hA1,       1, 10, 32'hB4,  0, 0,  7, 8,  1,  0,  1,  1,  1,  3,  32'hA1};
    tbl[6]  = '{1, 11, 32'hA2,       1, 10, 32'hB4,  0, 0,  7, 3,  0,  1,  1,  0,  1,  10, 32'hB4};
    tbl[7]  = '{1, 11, 32'hA2,       1, 7,  32'hC7,  0, 0,  7, 10, 0,  1,  1,  1,  1,  7,  32'hC7};
    tbl[8]  = '{1, 11, 32'hA2,       0, 0,  0,       0, 0,  7, 0,  1,  0,  1,  0,  1,  11, 32'hA2};
    tbl[9]  = '{0, 0,  0,            0, 0,  0,       0, 0,  7, 11, 0,  0,  0,  0,  0,  11, 32'hA2};
    tbl[10] = '{0, 0,  0,            1, 9,  32'hD9,  1, 9,  9, 0,  0,  1,  0,  0,  1,  9,  32'hD9};
    tbl[11] = '{0, 0,  0,            0, 0,  0,       0, 0,  9, 0,  0,  0,  1,  0,  0,  9,  32'hD9};
    tbl[12] = '{0, 0,  0,            0, 0,  0,       0, 0,  9, 0,  0,  0,  1,  0,  0,  9,  32'hD9};
    tbl[13] = '{1, 0,  1,            0, 0,  0,       1, 0,  0, 9,  1,  0,  0,  1,  0,  0,  1};
    tbl[14] = '{0, 0,  0,            0, 0,  0,       0, 0,  0, 9,  0,  0,  0,  1,  0,  0,  1};
    tbl[15] = '{0, 0,  0,            1, 9,  32'hE9,  0, 0,  0, 9,  0,  1,  0,  1,  1,  9,  32'hE9};
    tbl[16] = '{0, 0,  0,            0, 0,  0,       0, 0,  0, 9,  0,  0,  0,  1,  0,  9,  32'hE9};
    tbl[17] = '{0, 0,  0,            0, 0,  0,       0, 0,  0, 9,  0,  0,  0,  0,  0,  9,  32'hE9};

    rv = '{default: 0};
    rstn = 1'b0;
    drive(rv);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", 32'(rf_we), 0);
    check("reset_rf_rd", 32'(rf_rd), 0);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_ready", 32'({alu_ready, mem_ready}), 0);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      step(1'b1, tbl[i], $sformatf("t%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || last_alu_g) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd = AW'($urandom_range(0, 15));
        alu_data = $urandom;
      end
      if (!mem_valid || last_mem_g) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_rd = AW'($urandom_range(0, 15));
        mem_data = $urandom;
      end
      pend_set = ($urandom_range(0, 3) == 0);
      pend_rd = AW'($urandom_range(0, 15));
      rs1 = AW'($urandom_range(0, 15));
      rs2 = AW'($urandom_range(0, 15));
      step(1'b0, rv, $sformatf("r%0d", i));
    end

    rv = '{1, 12, 32'h1234, 0, 0, 0, 1, 13, 13, 12, 0, 0, 0, 0, 0, 0, 0};
    drive(rv);
    step(1'b0, rv, "pre_reset");
    rv = '{0, 0, 0, 0, 0, 0, 0, 0, 13, 12, 0, 0, 0, 0, 0, 0, 0};
    drive(rv);
    #2;
    check("pre_reset_rs1_busy", 32'(rs1_busy), 1);
    check("pre_reset_rf_we", 32'(rf_we), 1);
    rstn = 1'b0;
    #1;
    m_reset();
    check("midreset_rf_we", 32'(rf_we), 0);
    check("midreset_rf_rd", 32'(rf_rd), 0);
    check("midreset_rf_wdata", rf_wdata, 0);
    check("midreset_rs1_busy", 32'(rs1_busy), 0);
    check("midreset_rs2_busy", 32'(rs2_busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rv = '{1, 5, 32'hCAFE, 0, 0, 0, 0, 0, 13, 5, 0, 0, 0, 0, 0, 0, 0};
    drive(rv);
    step(1'b0, rv, "post_reset");
    check("post_reset_rf_wdata", rf_wdata, 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
